// File: rtl/vga_pattern_gen_if.sv
// VGA pattern generator pin bundle: mode select in, timing/colour out.
// The generator is the master; the consumer (pins / monitor) is the slave.
interface vga_pattern_gen_if #(
    parameter int CW = 4
);
    logic [1:0]    mode;
    logic          pix_en;
    logic          hsync;
    logic          vsync;
    logic          valid;
    logic [11:0]   hdata;
    logic [11:0]   vdata;
    logic          frame_start;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;

    modport master (
        input  mode,
        output pix_en, hsync, vsync, valid, hdata, vdata, frame_start, r, g, b
    );

    modport slave (
        output mode,
        input  pix_en, hsync, vsync, valid, hdata, vdata, frame_start, r, g, b
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with registered test-pattern colour.
// Optional horizontal scrolling of modes 0 and 2 when VGA_PATTERN_SCROLL_EN is defined.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0,
    parameter int CW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_pattern_gen_if.master     vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [11:0]   H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0]   V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0]   H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0]   V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0]   HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0]   HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0]   VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0]   VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_ON  = (SYNC_POL != 0);

    logic [DW-1:0] div_cnt;
    logic [11:0]   h;
    logic [11:0]   v;
    logic [1:0]    mode_q;
    logic          pix_en;

    logic          line_end;
    logic          frame_end;
    logic          origin;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic [1:0]    mode_cur;
    logic [2:0]    bar;
    logic [2:0]    bar_col;
    logic [CW-1:0] x_grad;
    logic          x_chk;
    logic [CW-1:0] r_nxt;
    logic [CW-1:0] g_nxt;
    logic [CW-1:0] b_nxt;

    // With CLK_DIV=1 the counter never leaves 0, so pix_en is constantly high.
    assign pix_en     = (div_cnt == DIV_LAST);
    assign vga.pix_en = pix_en;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [7:0] fc;
    logic [9:0] x_sum;

    // Only the low 10 bits of the scrolled coordinate feed the patterns.
    assign x_sum  = h[9:0] + {2'b00, fc};
    assign x_grad = x_sum[9:10-CW];
    assign x_chk  = x_sum[5];

    // Frame counter advancing on every frame wrap, wrapping naturally at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc <= 8'd0;
        end else if (pix_en && frame_end) begin
            fc <= fc + 8'd1;
        end
    end
`else
    assign x_grad = h[9:10-CW];
    assign x_chk  = h[5];
`endif

    // Pixel clock-enable divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Raster counters and frame-aligned mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            h      <= 12'd0;
            v      <= 12'd0;
            mode_q <= 2'd0;
        end else if (pix_en) begin
            h <= line_end ? 12'd0 : h + 12'd1;
            if (line_end) begin
                v <= frame_end ? 12'd0 : v + 12'd1;
            end
            if (origin) begin
                mode_q <= vga.mode;
            end
        end
    end

    // Decode the current raster position into sync, blanking and colour.
    always_comb begin
        line_end  = (h == H_LAST);
        frame_end = line_end && (v == V_LAST);
        origin    = (h == 12'd0) && (v == 12'd0);
        active    = (h < H_ACT) && (v < V_ACT);
        hs_on     = (h >= HS_START) && (h < HS_END);
        vs_on     = (v >= VS_START) && (v < VS_END);
        // Pixel (0,0) already uses the mode being latched on this strobe.
        mode_cur  = origin ? vga.mode : mode_q;

        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= 12'(i * (H_ACTIVE / 8))) begin
                bar = bar + 3'd1;
            end
        end
        bar_col = 3'd7 - bar;

        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (active) begin
            case (mode_cur)
                2'd0: begin
                    r_nxt = x_grad;
                    g_nxt = v[9:10-CW];
                    b_nxt = v[9:10-CW];
                end
                2'd1: begin
                    r_nxt = bar_col[2] ? {CW{1'b1}} : '0;
                    g_nxt = bar_col[1] ? {CW{1'b1}} : '0;
                    b_nxt = bar_col[0] ? {CW{1'b1}} : '0;
                end
                2'd2: begin
                    r_nxt = (x_chk ^ v[5]) ? {CW{1'b1}} : '0;
                    g_nxt = (x_chk ^ v[5]) ? {CW{1'b1}} : '0;
                    b_nxt = (x_chk ^ v[5]) ? {CW{1'b1}} : '0;
                end
                default: begin
                    r_nxt = {CW{1'b1}};
                    g_nxt = {CW{1'b1}};
                    b_nxt = {CW{1'b1}};
                end
            endcase
        end
    end

    // Output registers: one pixel period behind the counters, all aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.hsync       <= ~SYNC_ON;
            vga.vsync       <= ~SYNC_ON;
            vga.valid       <= 1'b0;
            vga.hdata       <= 12'd0;
            vga.vdata       <= 12'd0;
            vga.frame_start <= 1'b0;
            vga.r           <= '0;
            vga.g           <= '0;
            vga.b           <= '0;
        end else if (pix_en) begin
            vga.hsync       <= hs_on ? SYNC_ON : ~SYNC_ON;
            vga.vsync       <= vs_on ? SYNC_ON : ~SYNC_ON;
            vga.valid       <= active;
            vga.hdata       <= h;
            vga.vdata       <= v;
            vga.frame_start <= origin;
            vga.r           <= r_nxt;
            vga.g           <= g_nxt;
            vga.b           <= b_nxt;
        end
    end

endmodule
